fifo_rptr_empty_fwft: RTL
=========================

Name: fifo_rptr_empty_fwft

Overview:
- Read-side control of the dual-clock async FIFO: gray-coded read pointer, registered empty and almost-empty flags, read-side fill level, and a first-word-fall-through (FWFT) output register with a valid/ready handshake.
- Sits in the read clock domain.
- Consumes the write pointer already synchronised into this domain (rq2_wptr).
- Drives the memory read address and exports rptr to the write-domain synchroniser.

Parameters:
- ADDRSIZE, 4, memory address width; depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits.
- DATASIZE, 8, data word width.

Ports:
- rclk  input  1  read-domain clock.
- rrst  input  1  reset; synchronous, active-high.
- rq2_wptr  input  ADDRSIZE+1  gray write pointer, two-flop synchronised into rclk.
- rdata  input  DATASIZE  memory read data; combinational from raddr.
- raddr  output  ADDRSIZE  memory read address (binary).
- rptr  output  ADDRSIZE+1  registered gray read pointer, to the write-domain synchroniser.
- rempty  output  1  registered; memory holds no unread word.
- arempty  output  1  registered; memory holds at most 1 unread word.
- rlevel  output  ADDRSIZE+1  registered count of unread words in memory; excludes the output register.
- dout  output  DATASIZE  FWFT output data.
- dout_valid  output  1  dout holds a valid word.
- dout_ready  input  1  consumer accepts dout this cycle.

Behaviour:
- Reset (rrst=1 at a rclk edge) forces: rbin=0, rptr=0, raddr=0, rempty=1, arempty=1, rlevel=0, dout=0, dout_valid=0. rrst has priority over every other event.
- Internal pop: rinc = ~rempty & (~dout_valid | dout_ready).
- rbinnext = rbin + rinc, modulo 2**(ADDRSIZE+1).
- rgraynext = (rbinnext>>1) ^ rbinnext.
- rgraynextp1 = gray(rbinnext+1).
- Each edge: rbin <= rbinnext; rptr <= rgraynext.
- raddr = rbin[ADDRSIZE-1:0].
- rempty <= (rgraynext == rq2_wptr).
- arempty <= (rgraynext == rq2_wptr) | (rgraynextp1 == rq2_wptr).
- wbin_s = gray-to-binary of rq2_wptr.
- rlevel <= wbin_s - rbinnext, modulo 2**(ADDRSIZE+1); range 0..2**ADDRSIZE.
- Output register:
  - If rinc: dout <= rdata, dout_valid <= 1.
  - Else if dout_ready: dout_valid <= 0; dout holds its last value.
  - Else: dout and dout_valid hold.
- Latency: rq2_wptr changes at edge N → rempty falls at N+1 → dout_valid rises at N+2 with the word.
- Throughput: 1 word/cycle while memory is non-empty and dout_ready=1.
- Empty boundary:
  - rinc is never asserted while rempty=1, so there is no underflow.
  - dout_ready with dout_valid=0 is a no-op.
- Simultaneous accept and refill: dout_valid=1, dout_ready=1, rempty=0 → the new word loads and dout_valid stays 1, with no bubble.
- Backpressure: dout_valid=1, dout_ready=0 → dout is stable and rinc=0, so rptr does not advance.
- Wrap: rbin rolls 2**(ADDRSIZE+1)-1 → 0. The MSB flip distinguishes full from empty, and the flags remain correct across the wrap.
- Reset mid-operation: the pending dout is discarded. The system resets both domains together, so after reset rq2_wptr returns to 0.

Decomposition:
- Shared package fifo_pkg holds:
  - bin2gray and gray2bin functions, parameterised by width.
  - Reset-value constants for pointers and flags.
- One natural sub-module: fifo_gray2bin, a combinational XOR prefix chain for ADDRSIZE+1 bits. It is reused by the write side for a write-level output.
- Everything else stays in the top module.

Test Plan:
- Reset: rrst=1 for 2 cycles with arbitrary inputs → rempty=1, arempty=1, rptr=0, raddr=0, rlevel=0, dout_valid=0, dout=0.
- Single word: ADDRSIZE=4, mem[0]=0xA5, rq2_wptr 0→00001 at edge N, dout_ready=0 → rempty=0 at N+1; at N+2: dout=0xA5, dout_valid=1, rempty=1, rptr=00001. Everything holds while dout_ready=0.
- Full burst: rq2_wptr=gray(16)=11000, mem[i]=i, dout_ready=1 → rlevel=16 at N+1, then decrements by 1 each cycle. dout delivers 0x00..0x0F on 16 consecutive cycles, with arempty asserting at the final memory word. Afterwards rempty=1 and rptr=11000.
- Backpressure: 8 words queued, dout_ready toggling 1,0,0,1,... → output sequence is exactly 0..7 with no loss or duplication. rptr advances only on accepted cycles.
- Pointer wrap: rbin=31 (rptr=10000), then rq2_wptr advances by 2 to gray(1)=00001 → rptr goes 10000 → 00000 → 00001. Two words are delivered and rempty=1 at the end.
- Mid-operation reset: dout_valid=1 and rlevel=5; assert rrst with rq2_wptr forced to 0 → all outputs return to reset values at the next edge, and no stale word appears after rrst releases.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer logic: gray/binary conversion and reset values.
// Latency: none (functions and constants only).
// Backpressure: not applicable.
package fifo_pkg;

    // Widest pointer the conversion functions handle. Narrower pointers are zero-extended
    // on the way in and truncated on the way out. Zero bits above the real MSB leave
    // both conversions unchanged, so one function body serves any pointer width.
    localparam int GRAY_MAX_W = 32;

    localparam logic [GRAY_MAX_W-1:0] RST_PTR     = '0;
    localparam logic                  RST_EMPTY   = 1'b1;
    localparam logic                  RST_AREMPTY = 1'b1;
    localparam logic                  RST_VALID   = 1'b0;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Gray-to-binary converter: XOR prefix chain running from the MSB down.
// Latency: combinational.
// Backpressure: not applicable.
// Ports: gray (W-bit gray code in), bin (W-bit binary out).
module fifo_gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    always_comb begin
        bin        = '0;
        bin[W-1]   = gray[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
    end

endmodule

// File: rtl/fifo_rptr_empty_fwft.sv
// Read-side control of the async FIFO: gray read pointer, empty/almost-empty flags, fill level, FWFT output register.
// Latency: rq2_wptr change at edge N -> rempty low at N+1 -> dout_valid with the word at N+2.
// Backpressure: dout_valid & ~dout_ready holds dout and stops the read pointer.
// Ports: rclk/rrst (sync active-high reset); rq2_wptr synchronised gray write pointer in;
//        rdata/raddr memory read port; rptr gray pointer to the write domain;
//        rempty/arempty/rlevel memory occupancy; dout/dout_valid/dout_ready output handshake.
module fifo_rptr_empty_fwft
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE = 4,
    parameter int DATASIZE = 8
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [DATASIZE-1:0] rdata,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                arempty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic [DATASIZE-1:0] dout,
    output logic                dout_valid,
    input  logic                dout_ready
);

    localparam int PW = ADDRSIZE + 1;

    logic [PW-1:0]       rbin_q, rbin_d;
    logic [PW-1:0]       rptr_q, rptr_d;
    logic                rempty_q, rempty_d;
    logic                arempty_q, arempty_d;
    logic [PW-1:0]       rlevel_q, rlevel_d;
    logic [DATASIZE-1:0] dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;

    logic                rinc;
    logic [PW-1:0]       rbinnext;
    logic [PW-1:0]       rbinnext_p1;
    logic [PW-1:0]       rgraynext;
    logic [PW-1:0]       rgraynextp1;
    logic [PW-1:0]       wbin_s;

    fifo_gray2bin #(
        .W (PW)
    ) u_wptr_g2b (
        .gray (rq2_wptr),
        .bin  (wbin_s)
    );

    always_comb begin
        rbin_d       = rbin_q;
        rptr_d       = rptr_q;
        rempty_d     = rempty_q;
        arempty_d    = arempty_q;
        rlevel_d     = rlevel_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;

        // Pop from memory whenever the output register is free or being drained this
        // cycle; this is what gives back-to-back delivery with no bubble.
        rinc        = ~rempty_q & (~dout_valid_q | dout_ready);
        rbinnext    = rbin_q + PW'(rinc);
        rbinnext_p1 = rbinnext + PW'(1);
        rgraynext   = PW'(bin2gray(GRAY_MAX_W'(rbinnext)));
        rgraynextp1 = PW'(bin2gray(GRAY_MAX_W'(rbinnext_p1)));

        rbin_d    = rbinnext;
        rptr_d    = rgraynext;
        // Flags are computed from the post-pop pointer so they are correct the cycle
        // after a pop, not one cycle late.
        rempty_d  = (rgraynext == rq2_wptr);
        arempty_d = (rgraynext == rq2_wptr) | (rgraynextp1 == rq2_wptr);
        // Modulo-2**PW subtraction; the extra MSB makes a full memory read as 2**ADDRSIZE.
        rlevel_d  = wbin_s - rbinnext;

        if (rinc) begin
            dout_d       = rdata;
            dout_valid_d = 1'b1;
        end else if (dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin_q       <= PW'(RST_PTR);
            rptr_q       <= PW'(RST_PTR);
            rempty_q     <= RST_EMPTY;
            arempty_q    <= RST_AREMPTY;
            rlevel_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= RST_VALID;
        end else begin
            rbin_q       <= rbin_d;
            rptr_q       <= rptr_d;
            rempty_q     <= rempty_d;
            arempty_q    <= arempty_d;
            rlevel_q     <= rlevel_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign raddr      = rbin_q[ADDRSIZE-1:0];
    assign rptr       = rptr_q;
    assign rempty     = rempty_q;
    assign arempty    = arempty_q;
    assign rlevel     = rlevel_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule
